// File: rtl/ex_pkg.sv
// ---------------------------------------------------------------------------
// ex_pkg
// Shared types and constants for the execute stage and its mul/div unit.
//   alu_op_t   : 5-bit operation code presented by decode
//   md_state_t : mul/div sequencer state
//   md_op_t    : operation latched by the mul/div unit
//   is_md_op   : true for MULT/MULTU/DIV/DIVU
//   to_md_op   : maps an ALU op onto the mul/div operation encoding
// ---------------------------------------------------------------------------
package ex_pkg;

  typedef enum logic [4:0] {
    ALU_ADD   = 5'd0,
    ALU_ADDU  = 5'd1,
    ALU_SUB   = 5'd2,
    ALU_SUBU  = 5'd3,
    ALU_AND   = 5'd4,
    ALU_OR    = 5'd5,
    ALU_XOR   = 5'd6,
    ALU_NOR   = 5'd7,
    ALU_SLT   = 5'd8,
    ALU_SLTU  = 5'd9,
    ALU_LUI   = 5'd10,
    ALU_SLL   = 5'd11,
    ALU_SRL   = 5'd12,
    ALU_SRA   = 5'd13,
    ALU_MFHI  = 5'd14,
    ALU_MFLO  = 5'd15,
    ALU_MULT  = 5'd16,
    ALU_MULTU = 5'd17,
    ALU_DIV   = 5'd18,
    ALU_DIVU  = 5'd19
  } alu_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_t;

  localparam int          MD_CYCLES     = 32;
  localparam logic [4:0]  MD_LAST_COUNT = 5'(MD_CYCLES - 1);
  localparam logic [31:0] DIV0_LO       = 32'hFFFF_FFFF;

  function automatic logic is_md_op(input alu_op_t op);
    return (op == ALU_MULT) || (op == ALU_MULTU) ||
           (op == ALU_DIV)  || (op == ALU_DIVU);
  endfunction

  function automatic md_op_t to_md_op(input alu_op_t op);
    md_op_t r;
    case (op)
      ALU_MULTU: r = MD_MULTU;
      ALU_DIV:   r = MD_DIV;
      ALU_DIVU:  r = MD_DIVU;
      default:   r = MD_MULT;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ex_stage_muldiv.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// Iterative 32x32 multiply / 32/32 divide with HI/LO result registers.
// One shift-add (multiply) or restoring shift-subtract (divide) step per
// cycle, 32 steps per operation; signs are handled by working on magnitudes
// and fixing up the result on the final edge.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   start      : issue request, accepted only while IDLE
//   op         : MULT / MULTU / DIV / DIVU
//   a, b       : operands (a = multiplicand / dividend, b = multiplier / divisor)
//   busy       : high while an operation is in flight
//   hi, lo     : result registers
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no operation in flight, HI/LO hold the last result
// BUSY  | iterating; r_count counts steps down, last step at count 0
// ---------------------------------------------------------------------------
module muldiv_unit
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  md_op_t      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_t   r_state;
  md_state_t   w_state_nxt;
  logic [4:0]  r_count;
  logic        r_is_div;
  logic        r_div0;
  logic        r_neg_lo;   // product sign for multiply, quotient sign for divide
  logic        r_neg_hi;   // remainder sign (follows the dividend)
  logic [31:0] r_opnd;     // multiplicand / divisor magnitude
  logic [31:0] r_acc_hi;   // partial product high / partial remainder
  logic [31:0] r_acc_lo;   // multiplier bits / dividend bits -> quotient
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_last;
  logic        w_signed;
  logic        w_issue_div;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;

  logic [32:0] w_mul_sum;
  logic [31:0] w_mul_hi;
  logic [31:0] w_mul_lo;
  logic [32:0] w_div_shift;
  logic [32:0] w_div_diff;
  logic        w_div_ge;
  logic [31:0] w_div_hi;
  logic [31:0] w_div_lo;
  logic [31:0] w_step_hi;
  logic [31:0] w_step_lo;
  logic [63:0] w_prod;
  logic [63:0] w_prod_fix;

  assign w_last      = (r_count == 5'd0);
  assign w_signed    = (op == MD_MULT) || (op == MD_DIV);
  assign w_issue_div = (op == MD_DIV) || (op == MD_DIVU);
  assign w_a_mag     = (w_signed && a[31]) ? (32'd0 - a) : a;
  assign w_b_mag     = (w_signed && b[31]) ? (32'd0 - b) : b;

  // Multiply step: add multiplicand when the current multiplier bit is set,
  // then shift the 64-bit accumulator right by one.
  assign w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : 33'd0);
  assign w_mul_hi  = w_mul_sum[32:1];
  assign w_mul_lo  = {w_mul_sum[0], r_acc_lo[31:1]};

  // Restoring divide step: shift next dividend bit into the remainder and
  // keep the difference only when it did not go negative.
  assign w_div_shift = {r_acc_hi, r_acc_lo[31]};
  assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
  assign w_div_ge    = ~w_div_diff[32];
  assign w_div_hi    = w_div_ge ? w_div_diff[31:0] : w_div_shift[31:0];
  assign w_div_lo    = {r_acc_lo[30:0], w_div_ge};

  always_comb begin
    w_step_hi = r_acc_hi;
    w_step_lo = r_acc_lo;
    if (!r_div0) begin
      if (r_is_div) begin
        w_step_hi = w_div_hi;
        w_step_lo = w_div_lo;
      end else begin
        w_step_hi = w_mul_hi;
        w_step_lo = w_mul_lo;
      end
    end
  end

  assign w_prod     = {w_step_hi, w_step_lo};
  assign w_prod_fix = r_neg_lo ? (64'd0 - w_prod) : w_prod;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start)  w_state_nxt = BUSY;
      BUSY:    if (w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (r_state == BUSY);
  end

  assign hi = r_hi;
  assign lo = r_lo;

  // Datapath: operand capture, iteration and result write-back
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count  <= 5'd0;
      r_is_div <= 1'b0;
      r_div0   <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_opnd   <= 32'd0;
      r_acc_hi <= 32'd0;
      r_acc_lo <= 32'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_count  <= MD_LAST_COUNT;
            r_is_div <= w_issue_div;
            r_div0   <= w_issue_div && (b == 32'd0);
            r_neg_lo <= w_signed && (a[31] ^ b[31]);
            r_neg_hi <= w_signed && a[31];
            r_opnd   <= w_b_mag;
            r_acc_lo <= w_a_mag;
            // A zero divisor skips iteration; keep the raw dividend for HI.
            r_acc_hi <= (w_issue_div && (b == 32'd0)) ? a : 32'd0;
          end
        end
        BUSY: begin
          r_acc_hi <= w_step_hi;
          r_acc_lo <= w_step_lo;
          if (w_last) begin
            if (r_div0) begin
              r_hi <= r_acc_hi;
              r_lo <= DIV0_LO;
            end else if (r_is_div) begin
              r_hi <= r_neg_hi ? (32'd0 - w_step_hi) : w_step_hi;
              r_lo <= r_neg_lo ? (32'd0 - w_step_lo) : w_step_lo;
            end else begin
              r_hi <= w_prod_fix[63:32];
              r_lo <= w_prod_fix[31:0];
            end
          end else begin
            r_count <= r_count - 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage
// Execute stage of the five-stage MIPS R2000 pipeline. Computes the ALU
// result, selects the destination register, drives the mul/div unit and
// registers everything into the EX/MEM boundary.
// Ports:
//   clk, rst_n             : clock, synchronous active-low reset
//   wb_EX, m_EX            : write-back / memory control from decode
//   alu_op, alu_src        : operation, operand-B select (1 = imm)
//   reg_dst                : destination select (1 = rd, 0 = rt)
//   read_data_1/2, imm     : operands
//   shamt, rt, rd          : shift amount, register indices
//   wb, m                  : registered control to MEM
//   address_MEM            : registered ALU result
//   write_data_mem         : registered read_data_2
//   write_register_ex      : registered destination index
//   stall                  : combinational hold request to upstream stages
//   ovf                    : registered signed-overflow flag
// ---------------------------------------------------------------------------
module ex_stage
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  wb_EX,
  input  logic [1:0]  m_EX,
  input  alu_op_t     alu_op,
  input  logic        alu_src,
  input  logic        reg_dst,
  input  logic [31:0] read_data_1,
  input  logic [31:0] read_data_2,
  input  logic [31:0] imm,
  input  logic [4:0]  shamt,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  output logic [1:0]  wb,
  output logic [1:0]  m,
  output logic [31:0] address_MEM,
  output logic [31:0] write_data_mem,
  output logic [4:0]  write_register_ex,
  output logic        stall,
  output logic        ovf
);

  logic [31:0] w_b;
  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic [31:0] w_alu_res;
  logic        w_ovf;
  logic        w_is_md;
  logic        w_reads_hilo;
  logic        w_stall;
  logic        w_md_start;
  logic        w_md_busy;
  logic [31:0] w_hi;
  logic [31:0] w_lo;
  logic        w_suppress;

  logic [1:0]  r_wb;
  logic [1:0]  r_m;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [4:0]  r_wreg;
  logic        r_ovf;

  assign w_b    = alu_src ? imm : read_data_2;
  assign w_sum  = read_data_1 + w_b;
  assign w_diff = read_data_1 - w_b;

  always_comb begin
    w_alu_res = 32'd0;
    w_ovf     = 1'b0;
    case (alu_op)
      ALU_ADD: begin
        w_alu_res = w_sum;
        w_ovf     = (read_data_1[31] == w_b[31]) && (w_sum[31] != read_data_1[31]);
      end
      ALU_ADDU: w_alu_res = w_sum;
      ALU_SUB: begin
        w_alu_res = w_diff;
        w_ovf     = (read_data_1[31] != w_b[31]) && (w_diff[31] != read_data_1[31]);
      end
      ALU_SUBU: w_alu_res = w_diff;
      ALU_AND:  w_alu_res = read_data_1 & w_b;
      ALU_OR:   w_alu_res = read_data_1 | w_b;
      ALU_XOR:  w_alu_res = read_data_1 ^ w_b;
      ALU_NOR:  w_alu_res = ~(read_data_1 | w_b);
      ALU_SLT:  w_alu_res = {31'd0, $signed(read_data_1) < $signed(w_b)};
      ALU_SLTU: w_alu_res = {31'd0, read_data_1 < w_b};
      ALU_LUI:  w_alu_res = {w_b[15:0], 16'd0};
      ALU_SLL:  w_alu_res = w_b << shamt;
      ALU_SRL:  w_alu_res = w_b >> shamt;
      ALU_SRA:  w_alu_res = $signed(w_b) >>> shamt;
      ALU_MFHI: w_alu_res = w_hi;
      ALU_MFLO: w_alu_res = w_lo;
      default:  w_alu_res = 32'd0;
    endcase
  end

  assign w_is_md      = is_md_op(alu_op);
  assign w_reads_hilo = (alu_op == ALU_MFHI) || (alu_op == ALU_MFLO);

  // Gated by rst_n so upstream never sees a hold while the pipe is resetting.
  assign w_stall    = rst_n && w_md_busy && (w_is_md || w_reads_hilo);
  assign w_md_start = rst_n && w_is_md && !w_stall;
  assign w_suppress = w_ovf || w_is_md;

  muldiv_unit u_muldiv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_md_start),
    .op    (to_md_op(alu_op)),
    .a     (read_data_1),
    .b     (read_data_2),
    .busy  (w_md_busy),
    .hi    (w_hi),
    .lo    (w_lo)
  );

  // EX/MEM boundary. A stalled cycle inserts a bubble: control cleared,
  // data fields keep their previous contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wb    <= 2'b00;
      r_m     <= 2'b00;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_wreg  <= 5'd0;
      r_ovf   <= 1'b0;
    end else if (w_stall) begin
      r_wb    <= 2'b00;
      r_m     <= 2'b00;
      r_ovf   <= 1'b0;
    end else begin
      r_wb    <= w_suppress ? 2'b00 : wb_EX;
      r_m     <= w_suppress ? 2'b00 : m_EX;
      r_addr  <= w_alu_res;
      r_wdata <= read_data_2;
      r_wreg  <= reg_dst ? rd : rt;
      r_ovf   <= w_ovf;
    end
  end

  assign wb                = r_wb;
  assign m                 = r_m;
  assign address_MEM       = r_addr;
  assign write_data_mem    = r_wdata;
  assign write_register_ex = r_wreg;
  assign ovf               = r_ovf;
  assign stall             = w_stall;

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;
  import ex_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  wb_EX;
  logic [1:0]  m_EX;
  alu_op_t     alu_op;
  logic        alu_src;
  logic        reg_dst;
  logic [31:0] read_data_1;
  logic [31:0] read_data_2;
  logic [31:0] imm;
  logic [4:0]  shamt;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [1:0]  wb;
  logic [1:0]  m;
  logic [31:0] address_MEM;
  logic [31:0] write_data_mem;
  logic [4:0]  write_register_ex;
  logic        stall;
  logic        ovf;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .wb_EX             (wb_EX),
    .m_EX              (m_EX),
    .alu_op            (alu_op),
    .alu_src           (alu_src),
    .reg_dst           (reg_dst),
    .read_data_1       (read_data_1),
    .read_data_2       (read_data_2),
    .imm               (imm),
    .shamt             (shamt),
    .rt                (rt),
    .rd                (rd),
    .wb                (wb),
    .m                 (m),
    .address_MEM       (address_MEM),
    .write_data_mem    (write_data_mem),
    .write_register_ex (write_register_ex),
    .stall             (stall),
    .ovf               (ovf)
  );

  typedef struct {
    string       tag;
    bit          ctl_only;
    logic [31:0] addr;
    logic [1:0]  wb;
    logic [1:0]  m;
    logic        ovf;
    logic [4:0]  wreg;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic src, input logic [31:0] im, input logic [4:0] sh,
                       input logic dst, input logic [4:0] t, input logic [4:0] d,
                       input logic [1:0] w, input logic [1:0] mm);
    @(negedge clk);
    alu_op = op; read_data_1 = a; read_data_2 = b; alu_src = src; imm = im;
    shamt = sh; reg_dst = dst; rt = t; rd = d; wb_EX = w; m_EX = mm;
    #1;
  endtask

  task automatic push(input string tag, input bit ctl_only, input logic [31:0] addr,
                      input logic [1:0] w, input logic [1:0] mm, input logic o,
                      input logic [4:0] wr, input logic [31:0] wd);
    exp_t e;
    e.tag = tag; e.ctl_only = ctl_only; e.addr = addr; e.wb = w; e.m = mm;
    e.ovf = o; e.wreg = wr; e.wdata = wd;
    sb.push_back(e);
  endtask

  task automatic tick_check();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_total++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".wb"},  32'(wb),  32'(e.wb));
      chk({e.tag, ".m"},   32'(m),   32'(e.m));
      chk({e.tag, ".ovf"}, 32'(ovf), 32'(e.ovf));
      if (!e.ctl_only) begin
        chk({e.tag, ".addr"},  address_MEM,           e.addr);
        chk({e.tag, ".wreg"},  32'(write_register_ex), 32'(e.wreg));
        chk({e.tag, ".wdata"}, write_data_mem,        e.wdata);
      end
    end
  endtask

  // Plain ALU op: rt=2 destination, wb_EX=2'b10, m_EX=2'b01.
  task automatic alu_step(input string tag, input alu_op_t op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh,
                          input logic [31:0] exp_addr, input logic exp_ovf);
    drive(op, a, b, 1'b0, 32'h0, sh, 1'b0, 5'd2, 5'd3, 2'b10, 2'b01);
    chk({tag, ".stall"}, 32'(stall), 32'h0);
    push(tag, 1'b0, exp_addr, exp_ovf ? 2'b00 : 2'b10, exp_ovf ? 2'b00 : 2'b01,
         exp_ovf, 5'd2, b);
    tick_check();
  endtask

  task automatic md_issue(input string tag, input alu_op_t op, input logic [31:0] a,
                          input logic [31:0] b);
    drive(op, a, b, 1'b0, 32'h0, 5'd0, 1'b0, 5'd2, 5'd3, 2'b10, 2'b01);
    chk({tag, ".stall"}, 32'(stall), 32'h0);
    push(tag, 1'b1, 32'h0, 2'b00, 2'b00, 1'b0, 5'd0, 32'h0);
    tick_check();
  endtask

  // MFHI/MFLO: counts stalled cycles (each a bubble), then checks the value.
  task automatic md_read(input string tag, input alu_op_t op, input logic [31:0] exp_val,
                         input int exp_stalls);
    int n;
    drive(op, 32'h0, 32'h0, 1'b0, 32'h0, 5'd0, 1'b1, 5'd2, 5'd4, 2'b01, 2'b00);
    n = 0;
    while (stall === 1'b1 && n < 40) begin
      push({tag, ".bubble"}, 1'b1, 32'h0, 2'b00, 2'b00, 1'b0, 5'd0, 32'h0);
      tick_check();
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, ".stalls"}, 32'(n), 32'(exp_stalls));
    push(tag, 1'b0, exp_val, 2'b01, 2'b00, 1'b0, 5'd4, 32'h0);
    tick_check();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".wb"},    32'(wb),                32'h0);
    chk({tag, ".m"},     32'(m),                 32'h0);
    chk({tag, ".addr"},  address_MEM,            32'h0);
    chk({tag, ".wdata"}, write_data_mem,         32'h0);
    chk({tag, ".wreg"},  32'(write_register_ex), 32'h0);
    chk({tag, ".ovf"},   32'(ovf),               32'h0);
    chk({tag, ".stall"}, 32'(stall),             32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; wb_EX = 2'b00; m_EX = 2'b00; alu_op = ALU_ADD; alu_src = 1'b0;
    reg_dst = 1'b0; read_data_1 = 32'h0; read_data_2 = 32'h0; imm = 32'h0;
    shamt = 5'd0; rt = 5'd0; rd = 5'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // ALU directed steps
    alu_step("add_ovf",  ALU_ADD,  32'h7FFF_FFFF, 32'h1,         5'd0, 32'h8000_0000, 1'b1);
    alu_step("addu",     ALU_ADDU, 32'h7FFF_FFFF, 32'h1,         5'd0, 32'h8000_0000, 1'b0);
    alu_step("sub_ovf",  ALU_SUB,  32'h8000_0000, 32'h1,         5'd0, 32'h7FFF_FFFF, 1'b1);
    alu_step("subu",     ALU_SUBU, 32'h8000_0000, 32'h1,         5'd0, 32'h7FFF_FFFF, 1'b0);
    alu_step("add_neg",  ALU_ADD,  32'hFFFF_FFFE, 32'h5,         5'd0, 32'h0000_0003, 1'b0);
    alu_step("slt",      ALU_SLT,  32'hFFFF_FFFF, 32'h1,         5'd0, 32'h1,         1'b0);
    alu_step("sltu",     ALU_SLTU, 32'hFFFF_FFFF, 32'h1,         5'd0, 32'h0,         1'b0);
    alu_step("and",      ALU_AND,  32'hF0F0_1234, 32'hFF00_FF00, 5'd0, 32'hF000_1200, 1'b0);
    alu_step("or",       ALU_OR,   32'hF0F0_0000, 32'h0000_00FF, 5'd0, 32'hF0F0_00FF, 1'b0);
    alu_step("xor",      ALU_XOR,  32'hFFFF_0000, 32'hFF00_FF00, 5'd0, 32'h00FF_FF00, 1'b0);
    alu_step("nor",      ALU_NOR,  32'h0,         32'h0,         5'd0, 32'hFFFF_FFFF, 1'b0);
    alu_step("sll31",    ALU_SLL,  32'h0,         32'h1,         5'd31, 32'h8000_0000, 1'b0);
    alu_step("srl31",    ALU_SRL,  32'h0,         32'h8000_0000, 5'd31, 32'h1,        1'b0);

    // SRA with rd destination
    drive(ALU_SRA, 32'h0, 32'h8000_0000, 1'b0, 32'h0, 5'd4, 1'b1, 5'd2, 5'd9, 2'b11, 2'b00);
    push("sra_rd", 1'b0, 32'hF800_0000, 2'b11, 2'b00, 1'b0, 5'd9, 32'h8000_0000);
    tick_check();

    // Immediate operand: write data still comes from read_data_2
    drive(ALU_ADD, 32'd10, 32'hDEAD_BEEF, 1'b1, 32'd5, 5'd0, 1'b0, 5'd2, 5'd3, 2'b10, 2'b10);
    push("addi", 1'b0, 32'd15, 2'b10, 2'b10, 1'b0, 5'd2, 32'hDEAD_BEEF);
    tick_check();
    drive(ALU_LUI, 32'h0, 32'h0, 1'b1, 32'h0000_1234, 5'd0, 1'b0, 5'd7, 5'd3, 2'b10, 2'b00);
    push("lui", 1'b0, 32'h1234_0000, 2'b10, 2'b00, 1'b0, 5'd7, 32'h0);
    tick_check();

    // MULT -3 x 7; MFLO presented in N+1 stalls 32 cycles
    md_issue("mult", ALU_MULT, 32'hFFFF_FFFD, 32'd7);
    md_read("mult_lo", ALU_MFLO, 32'hFFFF_FFEB, 32);
    md_read("mult_hi", ALU_MFHI, 32'hFFFF_FFFF, 0);

    // DIV -7 / 2
    md_issue("div", ALU_DIV, 32'hFFFF_FFF9, 32'd2);
    md_read("div_lo", ALU_MFLO, 32'hFFFF_FFFD, 32);
    md_read("div_hi", ALU_MFHI, 32'hFFFF_FFFF, 0);

    // DIVU 0xFFFFFFFF / 16
    md_issue("divu", ALU_DIVU, 32'hFFFF_FFFF, 32'd16);
    md_read("divu_lo", ALU_MFLO, 32'h0FFF_FFFF, 32);
    md_read("divu_hi", ALU_MFHI, 32'h0000_000F, 0);

    // DIVU 5 / 0 with an unrelated ADD flowing during BUSY
    md_issue("div0", ALU_DIVU, 32'd5, 32'd0);
    alu_step("add_busy", ALU_ADD, 32'd3, 32'd4, 5'd0, 32'd7, 1'b0);
    md_read("div0_lo", ALU_MFLO, 32'hFFFF_FFFF, 31);
    md_read("div0_hi", ALU_MFHI, 32'd5, 0);

    // MULTU large operands
    md_issue("multu", ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    md_read("multu_hi", ALU_MFHI, 32'hFFFF_FFFE, 32);
    md_read("multu_lo", ALU_MFLO, 32'h0000_0001, 0);

    // Reset at N+10 of a MULT aborts it
    md_issue("mult_rst", ALU_MULT, 32'd1234, 32'd5678);
    for (int i = 1; i <= 9; i++)
      alu_step("fill", ALU_ADDU, 32'(i), 32'd1, 5'd0, 32'(i + 1), 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    alu_op = ALU_MFHI;
    #1;
    chk("rst_mid.stall_in_reset", 32'(stall), 32'h0);
    @(posedge clk);
    #1;
    chk_all_zero("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_mid.stall_after", 32'(stall), 32'h0);
    md_read("rst_hi", ALU_MFHI, 32'h0, 0);
    md_read("rst_lo", ALU_MFLO, 32'h0, 0);

    chk("scoreboard.drained", 32'(sb.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage MIPS R2000 pipeline, between the ID/EX register and the memory stage. Computes ALU results, selects the destination register and registers everything into the EX/MEM boundary that drives the memory stage. Contains the iterative multiply/divide unit with HI/LO registers and raises a stall toward upstream stages while a result is not yet available.

## Interface
- No parameters; data width fixed at 32, register index 5 bits.
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- wb_EX  in  2  write-back control from decode.
- m_EX  in  2  memory control from decode: [1] read, [0] write.
- alu_op  in  5  operation code, an `alu_op_t` from `ex_pkg`.
- alu_src  in  1  1 selects `imm` as operand B, 0 selects `read_data_2`.
- reg_dst  in  1  1 selects `rd`, 0 selects `rt` as destination.
- read_data_1, read_data_2  in  32  register operands A and B.
- imm  in  32  sign-extended immediate.
- shamt  in  5  shift amount.
- rt, rd  in  5  register indices.
- wb  out  2  registered write-back control to the memory stage.
- m  out  2  registered memory control.
- address_MEM  out  32  registered ALU result, also used as the memory address.
- write_data_mem  out  32  registered `read_data_2`.
- write_register_ex  out  5  registered destination index.
- stall  out  1  combinational; upstream holds PC, IF/ID and ID/EX while it is high.
- ovf  out  1  registered one-cycle overflow flag.

## Operation
- Operand B = `alu_src ? imm : read_data_2`.
- ALU ops:
  - ADD, ADDU, SUB, SUBU, AND, OR, XOR, NOR, SLT (signed), SLTU, LUI (`B<<16`).
  - SLL, SRL, SRA shift B by `shamt`.
  - MFHI, MFLO return HI or LO.
  - MULT, MULTU, DIV, DIVU issue to the mul/div unit.
- All arithmetic wraps at 32 bits.
- ADD/SUB signed overflow:
  - `wb` and `m` are forced to 0, so the write is suppressed.
  - `ovf` = 1 for that instruction's EX/MEM cycle.
- Mul/div ops force `wb` and `m` to 0 in EX/MEM. They never write a GPR.
- Mul/div unit states: IDLE and BUSY.
  - IDLE -> BUSY on issue when not stalled. Operands are latched as magnitudes and the count is loaded with 31.
  - BUSY: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle; the count decrements.
  - BUSY -> IDLE after the step at count 0. HI/LO are written on that edge.
- Multiply result: HI:LO = 64-bit product. For signed MULT the product is negated when the operand signs differ.
- Divide result: LO = quotient, truncated toward zero; HI = remainder, taking the sign of the dividend.
- Divide by zero, checked at issue:
  - No iteration; takes the same 32 cycles.
  - LO = 32'hFFFF_FFFF, HI = dividend.
- `stall` = 1 when the unit is BUSY and `alu_op` is MFHI, MFLO or any mul/div op.
- While `stall` is high:
  - EX/MEM loads a bubble: `wb`=0, `m`=0, `ovf`=0, others hold.
  - The instruction in EX is retried the next cycle.
- All other ops proceed while the unit is BUSY.

## Timing
- ALU result latency: 1 cycle. Inputs in cycle N appear on the EX/MEM outputs after edge N.
- Mul/div issued in cycle N:
  - BUSY in cycles N+1..N+32.
  - HI/LO are valid from cycle N+33.
  - An MFHI/MFLO presented in cycles N+1..N+32 stalls. Presented in N+33 it proceeds unstalled and returns the new value.
- Reset (`rst_n`=0 at an edge):
  - All outputs 0; HI, LO, count 0; state IDLE.
  - A reset mid-operation aborts it; HI/LO read 0 afterwards.
- `stall` is 0 during reset and in the cycle after.
- Reset overrides issue in the same cycle.

## Structure
- Package `ex_pkg`:
  - `alu_op_t` enum, 5 bits.
  - `md_state_t` {IDLE, BUSY}.
  - Constants `MD_CYCLES`=32 and `DIV0_LO`=32'hFFFF_FFFF.
- Sub-module `muldiv_unit`:
  - Inputs: clk, rst_n, start, op, a, b.
  - Outputs: busy, hi, lo.
- `ex_stage` holds the ALU, the muxes, the stall logic and the EX/MEM registers.

## Test plan
- ADD 32'h7FFF_FFFF + 1, `wb_EX`=2'b10 -> next cycle `address_MEM`=32'h8000_0000, `wb`=0, `ovf`=1. Same operands with ADDU -> `wb`=2'b10, `ovf`=0.
- SLT -1 vs 1 -> 1. SLTU -1 vs 1 -> 0. SRA 32'h8000_0000 by 4 -> 32'hF800_0000. `reg_dst`=1, `rd`=9 -> `write_register_ex`=9.
- MULT -3 × 7, then MFLO and MFHI -> LO=32'hFFFF_FFEB, HI=32'hFFFF_FFFF. MFLO presented in cycle N+1 holds `stall`=1 for 32 cycles with bubbles in EX/MEM.
- DIV -7 / 2 -> LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF. DIVU 32'hFFFF_FFFF / 16 -> LO=32'h0FFF_FFFF, HI=15.
- DIVU 5 / 0 -> after 32 cycles LO=32'hFFFF_FFFF, HI=5. An unrelated ADD issued during BUSY completes with no stall.
- Reset at cycle N+10 of a MULT -> all outputs 0 after the edge; a following MFHI returns 0 with no stall.
